// File: rtl/usd_apu_bridge.sv
`default_nettype none
// ============================================================================
// Module   : usd_apu_bridge
// Purpose  : Bridges single APU commands into a command FIFO and returns the
//            matching result (or a timeout) from a non-FWFT result FIFO.
//            Optional statistics counters: define USD_BRIDGE_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module usd_apu_bridge #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic        apuClk,
    input  logic        sysRst,
    input  logic        apuCmdValid,
    input  logic [71:0] apuCmdData,
    output logic        apuCmdReady,
    input  logic        cmdFifoFull,
    output logic        cmdFifoWrEn,
    output logic [71:0] cmdFifoData,
    input  logic        resultFifoEmpty,
    output logic        resultFifoRdEn,
    input  logic [35:0] resultFifoData,
    output logic        apuRespValid,
    output logic [35:0] apuRespData,
    output logic        apuRespTimeout,
    input  logic        apuRespAck,
    output logic        busy
`ifdef USD_BRIDGE_STATS_EN
    ,
    output logic [15:0] cmdCount,
    output logic [15:0] respCount,
    output logic [15:0] dropCount
`endif
);

    localparam logic [23:0] c_TIMEOUT_LAST = TIMEOUT_CYCLES - 24'd1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PUSH  = 3'd1,
        WAIT  = 3'd2,
        CAPT  = 3'd3,
        DRAIN = 3'd4,
        HOLD  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [23:0] r_timer;
    logic [71:0] r_cmdData;
    logic        r_respValid;
    logic [35:0] r_respData;
    logic        r_respTimeout;
    logic        w_cmdReady;
    logic        w_wrEn;
    logic        w_rdEn;
    logic        w_timeout;

    always_ff @(posedge apuClk) begin
        if (sysRst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_cmdReady  = 1'b0;
        w_wrEn      = 1'b0;
        w_rdEn      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                // A stray result is flushed before any new command is taken
                if (!resultFifoEmpty) begin
                    w_rdEn      = 1'b1;
                    w_nextState = DRAIN;
                end else begin
                    w_cmdReady = 1'b1;
                    if (apuCmdValid) begin
                        w_nextState = PUSH;
                    end
                end
            end
            PUSH: begin
                if (!cmdFifoFull) begin
                    w_wrEn      = 1'b1;
                    w_nextState = r_cmdData[71] ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (!resultFifoEmpty) begin
                    w_rdEn      = 1'b1;
                    w_nextState = CAPT;
                end else if (r_timer == c_TIMEOUT_LAST) begin
                    w_timeout   = 1'b1;
                    w_nextState = HOLD;
                end
            end
            CAPT:  w_nextState = HOLD;
            DRAIN: w_nextState = IDLE;
            HOLD: begin
                if (apuRespAck) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge apuClk) begin
        if (sysRst) begin
            r_timer       <= 24'd0;
            r_cmdData     <= 72'd0;
            r_respValid   <= 1'b0;
            r_respData    <= 36'd0;
            r_respTimeout <= 1'b0;
        end else begin
            if (w_cmdReady && apuCmdValid) begin
                r_cmdData <= apuCmdData;
            end
            if (r_state == PUSH) begin
                r_timer <= 24'd0;
            end else if (r_state == WAIT) begin
                r_timer <= r_timer + 24'd1;
            end
            // Result data is present on the FIFO one cycle after the read strobe
            if (r_state == CAPT) begin
                r_respData  <= resultFifoData;
                r_respValid <= 1'b1;
            end
            if (w_timeout) begin
                r_respData    <= 36'd0;
                r_respValid   <= 1'b1;
                r_respTimeout <= 1'b1;
            end
            if ((r_state == HOLD) && apuRespAck) begin
                r_respValid   <= 1'b0;
                r_respTimeout <= 1'b0;
            end
        end
    end

    // Strobes are suppressed while reset is asserted so an abandoned command
    // cannot emit a late write or read.
    assign apuCmdReady    = w_cmdReady & ~sysRst;
    assign cmdFifoWrEn    = w_wrEn & ~sysRst;
    assign resultFifoRdEn = w_rdEn & ~sysRst;
    assign cmdFifoData    = r_cmdData;
    assign apuRespValid   = r_respValid;
    assign apuRespData    = r_respData;
    assign apuRespTimeout = r_respTimeout;
    assign busy           = (r_state != IDLE);

`ifdef USD_BRIDGE_STATS_EN
    logic [15:0] r_cmdCount;
    logic [15:0] r_respCount;
    logic [15:0] r_dropCount;

    always_ff @(posedge apuClk) begin
        if (sysRst) begin
            r_cmdCount  <= 16'd0;
            r_respCount <= 16'd0;
            r_dropCount <= 16'd0;
        end else begin
            if (w_wrEn) begin
                r_cmdCount <= r_cmdCount + 16'd1;
            end
            if (r_state == CAPT) begin
                r_respCount <= r_respCount + 16'd1;
            end
            if ((r_state == DRAIN) || w_timeout) begin
                r_dropCount <= r_dropCount + 16'd1;
            end
        end
    end

    assign cmdCount  = r_cmdCount;
    assign respCount = r_respCount;
    assign dropCount = r_dropCount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_usd_apu_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_usd_apu_bridge
// Purpose  : Randomized scoreboard bench for usd_apu_bridge with FIFO models.
// Revision : 1.0  initial release
// ============================================================================
module tb_usd_apu_bridge;

    localparam int TO = 16;

    logic        apuClk = 1'b0;
    logic        sysRst = 1'b1;
    logic        apuCmdValid = 1'b0;
    logic [71:0] apuCmdData = 72'd0;
    logic        apuCmdReady;
    logic        cmdFifoFull = 1'b0;
    logic        cmdFifoWrEn;
    logic [71:0] cmdFifoData;
    logic        resultFifoEmpty = 1'b1;
    logic        resultFifoRdEn;
    logic [35:0] resultFifoData = 36'd0;
    logic        apuRespValid;
    logic [35:0] apuRespData;
    logic        apuRespTimeout;
    logic        apuRespAck = 1'b0;
    logic        busy;
`ifdef USD_BRIDGE_STATS_EN
    logic [15:0] cmdCount;
    logic [15:0] respCount;
    logic [15:0] dropCount;
`endif

    usd_apu_bridge #(.TIMEOUT_CYCLES(24'd16)) dut (
        .apuClk          (apuClk),
        .sysRst          (sysRst),
        .apuCmdValid     (apuCmdValid),
        .apuCmdData      (apuCmdData),
        .apuCmdReady     (apuCmdReady),
        .cmdFifoFull     (cmdFifoFull),
        .cmdFifoWrEn     (cmdFifoWrEn),
        .cmdFifoData     (cmdFifoData),
        .resultFifoEmpty (resultFifoEmpty),
        .resultFifoRdEn  (resultFifoRdEn),
        .resultFifoData  (resultFifoData),
        .apuRespValid    (apuRespValid),
        .apuRespData     (apuRespData),
        .apuRespTimeout  (apuRespTimeout),
        .apuRespAck      (apuRespAck),
        .busy            (busy)
`ifdef USD_BRIDGE_STATS_EN
        ,
        .cmdCount        (cmdCount),
        .respCount       (respCount),
        .dropCount       (dropCount)
`endif
    );

    always #5 apuClk = ~apuClk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        int          d;
        logic [35:0] res;
    } plan_t;

    typedef struct {
        logic [35:0] data;
        logic        to;
    } resp_t;

    typedef struct {
        int          due;
        logic [35:0] data;
    } pend_t;

    logic [71:0] expCmdQ[$];
    plan_t       planQ[$];
    resp_t       expRespQ[$];
    pend_t       pendQ[$];
    logic [35:0] rq[$];

    int expCmdCnt = 0;
    int expRespCnt = 0;
    int expDropCnt = 0;
    int delivered = 0;
    int nReads = 0;
    int expValidCyc = -1;
    int noResCheckCyc = -1;
    logic        rdSeen = 1'b0;
    logic        prevValid = 1'b0;
    logic        prevAck = 1'b0;
    logic [35:0] holdData = 36'd0;
    logic        holdTo = 1'b0;
    logic [63:0] junk;

    always @(posedge apuClk) cyc <= cyc + 1;

    // Result FIFO model: non-FWFT read data, scheduled result arrivals
    always @(posedge apuClk) begin
        #1;
        if (rdSeen && rq.size() > 0) begin
            resultFifoData = rq.pop_front();
        end else begin
            junk = {$urandom(), $urandom()};
            resultFifoData = junk[35:0];
        end
        while (pendQ.size() > 0 && pendQ[0].due <= cyc) begin
            rq.push_back(pendQ[0].data);
            pendQ.delete(0);
            delivered++;
        end
        resultFifoEmpty = (rq.size() == 0);
    end

    // Monitor: pops the scoreboard whenever the DUT presents a write or response
    always @(negedge apuClk) begin
        logic [71:0] c;
        plan_t       p;
        resp_t       e;
        pend_t       pe;
        rdSeen = resultFifoRdEn;
        chk("wr_when_full", 72'(cmdFifoWrEn & cmdFifoFull), 72'd0);
        chk("rd_when_empty", 72'(resultFifoRdEn & resultFifoEmpty), 72'd0);
        chk("ready_outside_idle_empty", 72'(apuCmdReady & (busy | ~resultFifoEmpty)), 72'd0);
        if (resultFifoRdEn) nReads++;
        if (cmdFifoWrEn) begin
            if (expCmdQ.size() == 0 || planQ.size() == 0) begin
                chk("unexpected_write", 72'd1, 72'd0);
            end else begin
                c = expCmdQ.pop_front();
                p = planQ.pop_front();
                chk("wr_data", cmdFifoData, c);
                expValidCyc = -1;
                if (c[71]) begin
                    noResCheckCyc = cyc + 1;
                end else if (p.d > 0) begin
                    pe.due  = cyc + p.d;
                    pe.data = p.res;
                    pendQ.push_back(pe);
                    expValidCyc = (p.d <= TO) ? cyc + p.d + 2 : cyc + TO + 1;
                end
            end
        end
        if (cyc == noResCheckCyc) begin
            chk("idle_ready_after_noresult", 72'({apuCmdReady, busy, resultFifoRdEn}), 72'b100);
        end
        if (apuRespValid && !prevValid) begin
            if (expRespQ.size() == 0) begin
                chk("unexpected_resp", 72'd1, 72'd0);
            end else begin
                e = expRespQ.pop_front();
                chk("resp_data", 72'(apuRespData), 72'(e.data));
                chk("resp_timeout", 72'(apuRespTimeout), 72'(e.to));
                chk("resp_latency", 72'(cyc), 72'(expValidCyc));
            end
            holdData = apuRespData;
            holdTo   = apuRespTimeout;
        end else if (apuRespValid) begin
            chk("hold_stable", 72'({apuRespData, apuRespTimeout}), 72'({holdData, holdTo}));
        end
        if (prevValid && prevAck) begin
            chk("clear_after_ack", 72'({apuRespValid, apuRespTimeout}), 72'd0);
        end
        prevValid = apuRespValid;
        prevAck   = apuRespAck;
    end

    task automatic waitSettle();
        int n = 0;
        @(negedge apuClk);
        while ((busy || !resultFifoEmpty || pendQ.size() > 0) && n < 200) begin
            @(negedge apuClk);
            n++;
        end
        if (n >= 200) chk("settle_timeout", 72'd1, 72'd0);
    endtask

    // Issue one command; d = result delay after the write (0 = never arrives)
    task automatic issue(input logic [71:0] cmd, input int fullCyc, input int d, input logic [35:0] res);
        plan_t p;
        resp_t e;
        int    n;
        logic [95:0] r;
        @(posedge apuClk); #1;
        apuCmdValid = 1'b1;
        apuCmdData  = cmd;
        cmdFifoFull = (fullCyc > 0);
        p.d = d;
        p.res = res;
        expCmdQ.push_back(cmd);
        planQ.push_back(p);
        expCmdCnt++;
        if (!cmd[71] && d > 0) begin
            e.to   = (d > TO);
            e.data = e.to ? 36'd0 : res;
            expRespQ.push_back(e);
            if (e.to) expDropCnt += 2;
            else      expRespCnt++;
        end
        n = 0;
        @(negedge apuClk);
        while (!apuCmdReady && n < 100) begin
            @(negedge apuClk);
            n++;
        end
        if (n >= 100) chk("handshake_timeout", 72'd1, 72'd0);
        @(posedge apuClk); #1;
        apuCmdValid = 1'b0;
        r = {$urandom(), $urandom(), $urandom()};
        apuCmdData = r[71:0];
        for (int i = 0; i < fullCyc; i++) begin
            @(negedge apuClk);
            chk("stall_data", cmdFifoData, cmd);
            chk("stall_no_wr", 72'(cmdFifoWrEn), 72'd0);
            @(posedge apuClk); #1;
        end
        cmdFifoFull = 1'b0;
        @(negedge apuClk);
        chk("wr_on_release", 72'(cmdFifoWrEn), 72'd1);
        if (cmd[71] || d == 0) return;
        n = 0;
        while (!apuRespValid && n < 100) begin
            @(negedge apuClk);
            n++;
        end
        if (n >= 100) chk("resp_wait_timeout", 72'd1, 72'd0);
        repeat ($urandom_range(0, 3)) @(negedge apuClk);
        @(posedge apuClk); #1;
        apuRespAck = 1'b1;
        @(posedge apuClk); #1;
        apuRespAck = 1'b0;
    endtask

    task automatic stray(input logic [35:0] data);
        pend_t pe;
        @(posedge apuClk); #1;
        pe.due  = cyc + 1;
        pe.data = data;
        pendQ.push_back(pe);
        expDropCnt++;
    endtask

    task automatic resetStats();
        expCmdCnt  = 0;
        expRespCnt = 0;
        expDropCnt = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [71:0] cmd;
        logic [95:0] r;
        logic [63:0] rr;
        repeat (3) @(posedge apuClk);
        #1 sysRst = 1'b0;
        @(negedge apuClk);
        chk("reset_outputs", 72'({apuRespValid, apuRespTimeout, apuRespData, cmdFifoWrEn, resultFifoRdEn, busy}), 72'd0);
        chk("reset_cmd_data", cmdFifoData, 72'd0);
        chk("reset_ready", 72'(apuCmdReady), 72'd1);

        // Reset in the middle of WAIT abandons the command
        issue({1'b0, 71'h12345}, 0, 0, 36'd0);
        repeat (5) @(posedge apuClk);
        #1 sysRst = 1'b1;
        @(negedge apuClk);
        chk("rst_cycle_strobes", 72'({cmdFifoWrEn, resultFifoRdEn}), 72'd0);
        @(posedge apuClk); #1 sysRst = 1'b0;
        resetStats();
        @(negedge apuClk);
        chk("rst_wait_outputs", 72'({apuRespValid, apuRespTimeout, apuRespData, cmdFifoWrEn, resultFifoRdEn, busy}), 72'd0);
        chk("rst_wait_cmd_data", cmdFifoData, 72'd0);
        chk("rst_wait_ready", 72'(apuCmdReady), 72'd1);
        @(posedge apuClk); #1 apuRespAck = 1'b1;
        @(posedge apuClk); #1 apuRespAck = 1'b0;
        @(negedge apuClk);
        chk("ack_in_idle_ignored", 72'({apuRespValid, busy}), 72'd0);

        issue({1'b0, 71'h0ABC_DEF0}, 0, 10, 36'h0000_00A5);
        waitSettle();
        issue({1'b0, 71'h5555_AAAA}, 5, 3, 36'h1_2345_6789);
        waitSettle();
        issue({1'b0, 71'h77}, 0, 25, 36'h9_8765_4321);
        waitSettle();
        issue({1'b1, 71'h4242}, 0, 0, 36'd0);
        waitSettle();
        issue({1'b0, 71'h16}, 1, 16, 36'hF_0000_0016);
        waitSettle();
        issue({1'b0, 71'h17}, 0, 17, 36'hF_0000_0017);
        waitSettle();
        stray(36'h3_3333_3333);
        issue({1'b0, 71'h99}, 2, 4, 36'h0_CAFE_F00D);
        waitSettle();

        for (int k = 0; k < 30; k++) begin
            r  = {$urandom(), $urandom(), $urandom()};
            cmd = r[71:0];
            cmd[71] = ($urandom_range(0, 3) == 0);
            rr = {$urandom(), $urandom()};
            if ($urandom_range(0, 5) == 0) stray(rr[63:28]);
            issue(cmd, $urandom_range(0, 4), cmd[71] ? 0 : $urandom_range(1, 22), rr[35:0]);
            waitSettle();
        end

        chk("scoreboard_empty", 72'(expRespQ.size() + expCmdQ.size() + planQ.size()), 72'd0);
        chk("reads_vs_results", 72'(nReads), 72'(delivered));
`ifdef USD_BRIDGE_STATS_EN
        chk("stat_cmd", 72'(cmdCount), 72'(expCmdCnt));
        chk("stat_resp", 72'(respCount), 72'(expRespCnt));
        chk("stat_drop", 72'(dropCount), 72'(expDropCnt));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
